// File: rtl/sync_vector_scheduler_pkg.sv
// sync_vector_scheduler_pkg: shared FSM encoding and width helpers for the vector scheduler
package sync_vector_scheduler_pkg;
   typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;
   function automatic int tag_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sync_vector_scheduler_rr_arbiter.sv
// sync_vector_scheduler_rr_arbiter: combinational round-robin pick of the first request at or above i_ptr
module sync_vector_scheduler_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_gnt_idx,
   output logic          o_any
);
   logic [N-1:0] w_rot;
   logic [IW:0]  w_sum;
   logic         w_found;
   always_comb begin
      w_rot   = N'({i_req, i_req} >> i_ptr);
      w_sum   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, i_ptr} + (IW+1)'(k);
         end
      end
      // offset found in the rotated view maps back to an absolute index mod N
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      o_gnt_idx = w_sum[IW-1:0];
      o_any     = |i_req;
      o_gnt     = o_any ? (N'(1) << o_gnt_idx) : '0;
   end
endmodule

// File: rtl/sync_vector_scheduler.sv
// sync_vector_scheduler: time-shares one synchronizer_vector crossing among NUM_REQ sources, one {seq,tag,data} word per hold period
module sync_vector_scheduler
   import sync_vector_scheduler_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int HOLD_CYCLES = 16,
   localparam int TAG_W      = tag_w(NUM_REQ),
   localparam int WORD_W     = 1 + TAG_W + DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [WORD_W-1:0]             sync_word,
   output logic                          busy
);
   localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_seq;
   logic [TAG_W-1:0]     r_ptr;
   logic [NUM_REQ-1:0]   r_gnt_oh;
   logic [NUM_REQ-1:0]   r_ack;
   logic [WORD_W-1:0]    r_word;
   logic [NUM_REQ-1:0]   w_gnt;
   logic [TAG_W-1:0]     w_gnt_idx;
   logic                 w_any;
   logic                 w_launch;
   logic                 w_done;

   sync_vector_scheduler_rr_arbiter #(.N(NUM_REQ), .IW(TAG_W)) u_arb (
      .i_req     (req_valid),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_any)
   );

   always_comb begin
      w_launch    = (r_state == S_IDLE) && w_any;
      w_done      = (r_state == S_HOLD) && (r_cnt == '0);
      w_state_nxt = w_launch ? S_HOLD : w_done ? S_IDLE : r_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_seq    <= 1'b0;
         r_ptr    <= '0;
         r_gnt_oh <= '0;
         r_ack    <= '0;
         r_word   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_done ? r_gnt_oh : '0;
         if (w_launch) begin
            // payload is captured only here; later req_data changes wait for the next grant
            r_word   <= {~r_seq, w_gnt_idx, req_data[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH]};
            r_seq    <= ~r_seq;
            r_gnt_oh <= w_gnt;
            r_cnt    <= CNT_W'(HOLD_CYCLES - 1);
            r_ptr    <= (w_gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + TAG_W'(1);
         end else if ((r_state == S_HOLD) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign req_ack   = r_ack;
   assign sync_word = r_word;
   assign busy      = (r_state == S_HOLD);
endmodule

// File: tb/tb_sync_vector_scheduler.sv
// tb_sync_vector_scheduler: directed vectors checked each cycle against a transaction-level scheduler model
module tb_sync_vector_scheduler;
   localparam int N  = 4;
   localparam int D  = 32;
   localparam int H  = 16;
   localparam int TW = 2;
   localparam int WW = 1 + TW + D;

   logic            clk = 1'b0;
   logic            new_clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*D-1:0]  req_data = '0;
   logic [N-1:0]    req_ack;
   logic [WW-1:0]   sync_word;
   logic            busy;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   sync_vector_scheduler #(.NUM_REQ(N), .DATA_WIDTH(D), .HOLD_CYCLES(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ack   (req_ack),
      .sync_word (sync_word),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always #15 new_clk = ~new_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: a launch makes the word visible for H busy cycles, then one ack cycle
   logic [WW-1:0] m_word = '0;
   bit            m_seq = 1'b0;
   int            m_ptr = 0;
   int            m_left = 0;
   int            m_gnt = 0;
   logic [N-1:0]  m_ack = '0;
   always @(posedge clk) begin
      if (rst) begin
         m_word = '0; m_seq = 1'b0; m_ptr = 0; m_left = 0; m_ack = '0;
      end else if (m_left > 0) begin
         m_ack  = (m_left == 1) ? N'(1) << m_gnt : '0;
         m_left = m_left - 1;
      end else begin
         m_ack = '0;
         if (|req_valid) begin
            for (int k = N - 1; k >= 0; k--)
               if (req_valid[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
            m_seq  = ~m_seq;
            m_word = {m_seq, TW'(m_gnt), req_data[m_gnt*D +: D]};
            m_left = H;
            m_ptr  = (m_gnt + 1) % N;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("word", 64'(sync_word), 64'(m_word));
         chk("busy", 64'(busy), 64'(m_left > 0));
         chk("ack", 64'(req_ack), 64'(m_ack));
      end
   end

   // slow receive side: double-flop sync then count observed word changes
   logic [WW-1:0] s1 = '0, s2 = '0, s3 = '0;
   int n_chg = 0;
   always @(posedge new_clk) begin
      if (s2 !== s3) n_chg++;
      s1 <= sync_word;
      s2 <= s1;
      s3 <= s2;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic wait_ack(output logic [N-1:0] a, output int nb);
      nb = int'(busy);
      a = '0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (busy) nb++;
         if (req_ack != '0) begin
            a = req_ack;
            return;
         end
      end
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: got none expected ack within 60 cycles at %0t", $time);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] a;
      int nb, c0;
      longint t[4];
      logic [WW-1:0] w1;
      @(posedge clk);
      chk_en = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(50);
      chk("idle_word", 64'(sync_word), 64'h0);
      chk("idle_busy", 64'(busy), 64'h0);

      req_data[2*D +: D] = 32'hDEADBEEF;
      req_valid = 4'b0100;
      tick();
      chk("t2_word", 64'(sync_word), 64'h6DEADBEEF);
      wait_ack(a, nb);
      chk("t2_busy_cycles", 64'(nb), 64'd16);
      chk("t2_ack", 64'(a), 64'b0100);
      req_valid = '0;
      tick(3);
      chk("t2_ack_width", 64'(req_ack), 64'h0);

      do_reset();
      for (int i = 0; i < N; i++) req_data[i*D +: D] = 32'h11111111 * (i + 1);
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
         tick();
         t[i] = longint'($time);
         chk("t3_tag", 64'(sync_word[WW-2 -: TW]), 64'(i));
         chk("t3_seq", 64'(sync_word[WW-1]), 64'((i % 2) == 0));
         wait_ack(a, nb);
         chk("t3_ack", 64'(a), 64'(N'(1) << i));
         req_valid = req_valid & ~a;
      end
      chk("t3_gap", 64'(t[1] - t[0]), 64'd170);
      chk("t3_span", 64'(t[3] - t[0]), 64'd510);

      do_reset();
      tick(12);
      c0 = n_chg;
      req_data[3*D +: D] = 32'h0;
      req_valid = 4'b1000;
      tick();
      chk("t4_word1", 64'(sync_word), 64'h700000000);
      w1 = sync_word;
      wait_ack(a, nb);
      chk("t4_ack1", 64'(a), 64'b1000);
      tick();
      chk("t4_word2", 64'(sync_word), 64'h300000000);
      chk("t4_seq_only", 64'(w1 ^ sync_word), 64'h400000000);
      wait_ack(a, nb);
      req_valid = '0;
      tick(20);
      chk("t4_rx_changes", 64'(n_chg - c0), 64'd2);

      do_reset();
      req_data[1*D +: D] = 32'hCAFEF00D;
      req_valid = 4'b0010;
      tick();
      chk("t5_word", 64'(sync_word), 64'h5CAFEF00D);
      tick(4);
      rst = 1'b1;
      req_valid = '0;
      tick();
      chk("t5_rst_word", 64'(sync_word), 64'h0);
      chk("t5_rst_busy", 64'(busy), 64'h0);
      rst = 1'b0;
      tick();
      chk("t5_no_ack", 64'(req_ack), 64'h0);
      req_data[0 +: D] = 32'h12345678;
      req_valid = 4'b0001;
      tick();
      chk("t5_fresh_word", 64'(sync_word), 64'h412345678);
      wait_ack(a, nb);
      chk("t5_fresh_ack", 64'(a), 64'b0001);
      req_valid = '0;

      do_reset();
      req_data[1*D +: D] = 32'hA5A5A5A5;
      req_valid = 4'b0010;
      tick();
      chk("t6_word", 64'(sync_word), 64'h5A5A5A5A5);
      tick(3);
      req_data[1*D +: D] = 32'hFFFFFFFF;
      req_valid = '0;
      wait_ack(a, nb);
      chk("t6_ack", 64'(a), 64'b0010);
      chk("t6_word_frozen", 64'(sync_word), 64'h5A5A5A5A5);
      tick(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
